// File: rtl/enemy_hp_ctrl.sv
// Enemy/boss hit-point bookkeeping: edge-detected hits, saturating damage,
// enemy respawn timers, Reimu invincibility window and registered hit pulses.
module enemy_hp_ctrl #(
    parameter logic [6:0] ENM_HP_INIT   = 7'd20,
    parameter logic [6:0] ENM_DMG       = 7'd5,
    parameter logic [9:0] BOSS_HP_INIT  = 10'd500,
    parameter logic [9:0] BOSS_DMG      = 10'd10,
    parameter logic [7:0] RESPAWN_TICKS = 8'd64,
    parameter logic [7:0] INV_TICKS     = 8'd32
) (
    input  logic       clk22,
    input  logic       rst,
    input  logic       gamestart,
    input  logic [3:0] hit_enm,
    input  logic       hit_boss,
    input  logic       boss_active,
    input  logic       hit_reimu,
    output logic [6:0] enmhp1,
    output logic [6:0] enmhp2,
    output logic [6:0] enmhp3,
    output logic [6:0] enmhp4,
    output logic [9:0] bosshp,
    output logic       shot_enm,
    output logic       shot_boss,
    output logic       shot_reimu,
    output logic       reimu_inv
);

    typedef enum logic {ENM_ALIVE, ENM_DEAD} enm_state_e;
    typedef enum logic {INV_OFF, INV_ON} inv_state_e;

    enm_state_e enm_state_q [4];
    enm_state_e enm_state_d [4];
    logic [6:0] enm_hp_q    [4];
    logic [6:0] enm_hp_d    [4];
    logic [7:0] enm_cnt_q   [4];
    logic [7:0] enm_cnt_d   [4];

    logic [3:0] hit_enm_prev_q,   hit_enm_prev_d;
    logic       hit_boss_prev_q,  hit_boss_prev_d;
    logic       hit_reimu_prev_q, hit_reimu_prev_d;

    logic [9:0] boss_hp_q,   boss_hp_d;
    logic       boss_pend_q, boss_pend_d;

    inv_state_e inv_state_q, inv_state_d;
    logic [7:0] inv_cnt_q,   inv_cnt_d;

    logic shot_enm_q,   shot_enm_d;
    logic shot_boss_q,  shot_boss_d;
    logic shot_reimu_q, shot_reimu_d;

    logic [3:0] enm_edge;
    logic       boss_hit;
    logic       enm_any_hit;

    always_comb begin
        enm_state_d      = enm_state_q;
        enm_hp_d         = enm_hp_q;
        enm_cnt_d        = enm_cnt_q;
        hit_enm_prev_d   = hit_enm;
        hit_boss_prev_d  = hit_boss;
        hit_reimu_prev_d = hit_reimu;
        boss_hp_d        = boss_hp_q;
        boss_pend_d      = boss_pend_q;
        inv_state_d      = inv_state_q;
        inv_cnt_d        = inv_cnt_q;
        shot_enm_d       = 1'b0;
        shot_boss_d      = 1'b0;
        shot_reimu_d     = 1'b0;
        enm_any_hit      = 1'b0;
        boss_hit         = 1'b0;
        enm_edge         = hit_enm & ~hit_enm_prev_q;

        for (int unsigned i = 0; i < 4; i++) begin
            case (enm_state_q[i])
                ENM_ALIVE: begin
                    if (enm_edge[i] && enm_hp_q[i] != '0) begin
                        enm_any_hit = 1'b1;
                        if (enm_hp_q[i] <= ENM_DMG) begin
                            enm_hp_d[i]    = '0;
                            enm_cnt_d[i]   = RESPAWN_TICKS;
                            enm_state_d[i] = ENM_DEAD;
                        end else begin
                            enm_hp_d[i] = enm_hp_q[i] - ENM_DMG;
                        end
                    end
                end
                default: begin
                    // Reload on the last count so HP sits at 0 for exactly RESPAWN_TICKS cycles
                    if (enm_cnt_q[i] <= 8'd1) begin
                        enm_hp_d[i]    = ENM_HP_INIT;
                        enm_cnt_d[i]   = '0;
                        enm_state_d[i] = ENM_ALIVE;
                    end else begin
                        enm_cnt_d[i] = enm_cnt_q[i] - 8'd1;
                    end
                end
            endcase
        end
        shot_enm_d = enm_any_hit;

        if (hit_boss && !hit_boss_prev_q && boss_active && boss_hp_q != '0) begin
            boss_hit  = 1'b1;
            boss_hp_d = (boss_hp_q <= BOSS_DMG) ? '0 : boss_hp_q - BOSS_DMG;
        end

        // Enemy pulse wins the cycle; a deferred boss pulse goes out before a new one
        if (enm_any_hit) begin
            boss_pend_d = boss_pend_q | boss_hit;
        end else if (boss_pend_q) begin
            shot_boss_d = 1'b1;
            boss_pend_d = boss_hit;
        end else begin
            shot_boss_d = boss_hit;
            boss_pend_d = 1'b0;
        end

        case (inv_state_q)
            INV_OFF: begin
                if (hit_reimu && !hit_reimu_prev_q) begin
                    shot_reimu_d = 1'b1;
                    inv_state_d  = INV_ON;
                    inv_cnt_d    = INV_TICKS;
                end
            end
            default: begin
                if (inv_cnt_q <= 8'd1) begin
                    inv_state_d = INV_OFF;
                    inv_cnt_d   = '0;
                end else begin
                    inv_cnt_d = inv_cnt_q - 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk22) begin
        if (rst || gamestart) begin
            for (int unsigned i = 0; i < 4; i++) begin
                enm_state_q[i] <= ENM_ALIVE;
                enm_hp_q[i]    <= ENM_HP_INIT;
                enm_cnt_q[i]   <= '0;
            end
            hit_enm_prev_q   <= '0;
            hit_boss_prev_q  <= 1'b0;
            hit_reimu_prev_q <= 1'b0;
            boss_hp_q        <= BOSS_HP_INIT;
            boss_pend_q      <= 1'b0;
            inv_state_q      <= INV_OFF;
            inv_cnt_q        <= '0;
            shot_enm_q       <= 1'b0;
            shot_boss_q      <= 1'b0;
            shot_reimu_q     <= 1'b0;
        end else begin
            enm_state_q      <= enm_state_d;
            enm_hp_q         <= enm_hp_d;
            enm_cnt_q        <= enm_cnt_d;
            hit_enm_prev_q   <= hit_enm_prev_d;
            hit_boss_prev_q  <= hit_boss_prev_d;
            hit_reimu_prev_q <= hit_reimu_prev_d;
            boss_hp_q        <= boss_hp_d;
            boss_pend_q      <= boss_pend_d;
            inv_state_q      <= inv_state_d;
            inv_cnt_q        <= inv_cnt_d;
            shot_enm_q       <= shot_enm_d;
            shot_boss_q      <= shot_boss_d;
            shot_reimu_q     <= shot_reimu_d;
        end
    end

    assign enmhp1     = enm_hp_q[0];
    assign enmhp2     = enm_hp_q[1];
    assign enmhp3     = enm_hp_q[2];
    assign enmhp4     = enm_hp_q[3];
    assign bosshp     = boss_hp_q;
    assign shot_enm   = shot_enm_q;
    assign shot_boss  = shot_boss_q;
    assign shot_reimu = shot_reimu_q;
    assign reimu_inv  = (inv_state_q == INV_ON);

endmodule
